// File: rtl/pe_array_ctrl.sv
// pe_array_ctrl: sequencer for a cellular PE array.
// Streams a raster load into the array, issues a counted number of STEP
// generations, and streams the array contents back out with a valid/ready
// handshake. The array is x-fastest raster addressed; reads are expected to be
// combinational from adr_x_o/adr_y_o.
module pe_array_ctrl #(
  parameter int N_PX          = 16,
  parameter int N_PY          = 16,
  parameter int PE_STATE_BITS = 1,
  parameter int PE_CMD_BITS   = 2,
  parameter int CMD_NOP       = 0,
  parameter int CMD_LOAD      = 1,
  parameter int CMD_STEP      = 2,
  parameter int GEN_BITS      = 16,
  localparam int XB = (N_PX > 1) ? $clog2(N_PX) : 1,
  localparam int YB = (N_PY > 1) ? $clog2(N_PY) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start_load,
  input  logic                     start_run,
  input  logic [GEN_BITS-1:0]      run_gens,
  input  logic                     start_dump,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [PE_STATE_BITS-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [PE_STATE_BITS-1:0] out_data,
  output logic                     out_last,
  output logic                     busy,
  output logic                     done,
  output logic [GEN_BITS-1:0]      gen_cnt,
  output logic [PE_CMD_BITS-1:0]   cmd,
  output logic [PE_STATE_BITS-1:0] state_out,
  output logic [XB-1:0]            adr_x_i,
  output logic [YB-1:0]            adr_y_i,
  output logic [XB-1:0]            adr_x_o,
  output logic [YB-1:0]            adr_y_o,
  input  logic [PE_STATE_BITS-1:0] state_in,
  input  logic                     active
);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    DUMP_ADDR,
    DUMP_HOLD
  } state_e;

  state_e state_q, state_d;

  logic [XB-1:0]            xCnt_q, xCnt_d;
  logic [YB-1:0]            yCnt_q, yCnt_d;
  logic [GEN_BITS-1:0]      genCnt_q, genCnt_d;
  logic [GEN_BITS-1:0]      genTarget_q, genTarget_d;
  logic [PE_STATE_BITS-1:0] outData_q, outData_d;
  logic                     outValid_q, outValid_d;
  logic                     outLast_q, outLast_d;

  logic lastCell;
  logic loadBeat;
  logic dumpAccept;
  logic runDone;
  logic anyStart;

  // The activity flag has no role in sequencing generations.
  logic unusedActive;
  assign unusedActive = active;

  assign lastCell   = (xCnt_q == XB'(N_PX - 1)) && (yCnt_q == YB'(N_PY - 1));
  assign loadBeat   = (state_q == LOAD) && in_valid;
  assign dumpAccept = (state_q == DUMP_HOLD) && out_ready;
  assign runDone    = (state_q == RUN) && (genCnt_q == genTarget_q);
  assign anyStart   = start_load || start_run || start_dump;

  // State register; reset drops straight back to IDLE, aborting any operation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; starts are only looked at in IDLE, load wins over run over dump.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start_load)      state_d = LOAD;
        else if (start_run)  state_d = RUN;
        else if (start_dump) state_d = DUMP_ADDR;
      end
      LOAD:      if (loadBeat && lastCell) state_d = IDLE;
      RUN:       if (runDone) state_d = IDLE;
      DUMP_ADDR: state_d = DUMP_HOLD;
      DUMP_HOLD: if (dumpAccept) state_d = lastCell ? IDLE : DUMP_ADDR;
      default:   state_d = IDLE;
    endcase
  end

  // Datapath next values: raster counters, generation count and the dump output register.
  always_comb begin
    xCnt_d      = xCnt_q;
    yCnt_d      = yCnt_q;
    genCnt_d    = genCnt_q;
    genTarget_d = genTarget_q;
    outData_d   = outData_q;
    outValid_d  = outValid_q;
    outLast_d   = outLast_q;

    if ((state_q == IDLE) && anyStart) begin
      xCnt_d = '0;
      yCnt_d = '0;
    end

    if ((state_q == IDLE) && !start_load && start_run) begin
      genCnt_d    = '0;
      genTarget_d = run_gens;
    end

    if (loadBeat || dumpAccept) begin
      if (xCnt_q == XB'(N_PX - 1)) begin
        xCnt_d = '0;
        yCnt_d = (yCnt_q == YB'(N_PY - 1)) ? '0 : yCnt_q + YB'(1);
      end else begin
        xCnt_d = xCnt_q + XB'(1);
      end
    end

    if ((state_q == RUN) && !runDone) begin
      genCnt_d = genCnt_q + GEN_BITS'(1);
    end

    if (state_q == DUMP_ADDR) begin
      outData_d  = state_in;
      outValid_d = 1'b1;
      outLast_d  = lastCell;
    end

    if (dumpAccept) begin
      outValid_d = 1'b0;
      outLast_d  = 1'b0;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      xCnt_q      <= '0;
      yCnt_q      <= '0;
      genCnt_q    <= '0;
      genTarget_q <= '0;
      outData_q   <= '0;
      outValid_q  <= 1'b0;
      outLast_q   <= 1'b0;
    end else begin
      xCnt_q      <= xCnt_d;
      yCnt_q      <= yCnt_d;
      genCnt_q    <= genCnt_d;
      genTarget_q <= genTarget_d;
      outData_q   <= outData_d;
      outValid_q  <= outValid_d;
      outLast_q   <= outLast_d;
    end
  end

  // Array command/address outputs and the done pulse, issued in the completing cycle.
  always_comb begin
    in_ready  = 1'b0;
    cmd       = PE_CMD_BITS'(CMD_NOP);
    state_out = '0;
    adr_x_i   = '0;
    adr_y_i   = '0;
    adr_x_o   = '0;
    adr_y_o   = '0;
    done      = 1'b0;
    case (state_q)
      LOAD: begin
        in_ready = 1'b1;
        adr_x_i  = xCnt_q;
        adr_y_i  = yCnt_q;
        if (in_valid) begin
          cmd       = PE_CMD_BITS'(CMD_LOAD);
          state_out = in_data;
          done      = lastCell;
        end
      end
      RUN: begin
        if (runDone) done = 1'b1;
        else         cmd  = PE_CMD_BITS'(CMD_STEP);
      end
      DUMP_ADDR: begin
        adr_x_o = xCnt_q;
        adr_y_o = yCnt_q;
      end
      DUMP_HOLD: begin
        adr_x_o = xCnt_q;
        adr_y_o = yCnt_q;
        done    = out_ready && lastCell;
      end
      default: ;
    endcase
  end

  assign busy      = (state_q != IDLE);
  assign out_valid = outValid_q;
  assign out_data  = outData_q;
  assign out_last  = outLast_q;
  assign gen_cnt   = genCnt_q;

endmodule

// File: doc/pe_array_ctrl.md
PE_ARRAY_CTRL -- requirements
Module: pe_array_ctrl

Interface
REQ-001 SHALL have parameter N_PX, default 16, meaning array columns.
REQ-002 SHALL have parameter N_PY, default 16, meaning array rows.
REQ-003 SHALL have parameter PE_STATE_BITS, default 1, meaning cell state width.
REQ-004 SHALL have parameter PE_CMD_BITS, default 2, meaning array command width.
REQ-005 SHALL have parameters CMD_NOP=0, CMD_LOAD=1, CMD_STEP=2, meaning array command encodings.
REQ-006 SHALL have parameter GEN_BITS, default 16, meaning generation counter width.
REQ-007 SHALL define XB=$clog2(N_PX) and YB=$clog2(N_PY), each with a minimum of 1.
REQ-008 clk  in  1  single clock; all state on the rising edge.
REQ-009 reset  in  1  asynchronous, active-high reset.
REQ-010 start_load  in  1  pulse; begin a raster load of N_PX*N_PY cells.
REQ-011 start_run  in  1  pulse; begin run_gens generations.
REQ-012 run_gens  in  GEN_BITS  generation count, sampled when start_run is accepted.
REQ-013 start_dump  in  1  pulse; begin a raster readout of all cells.
REQ-014 in_valid / in_ready  in / out  1 / 1  load-stream handshake.
REQ-015 in_data  in  PE_STATE_BITS  load cell value.
REQ-016 out_valid / out_ready  out / in  1 / 1  dump-stream handshake.
REQ-017 out_data / out_last  out  PE_STATE_BITS / 1  dump cell value; out_last is high on the final cell.
REQ-018 busy / done  out  1 / 1  busy = not IDLE; done = one-cycle pulse when an operation completes.
REQ-019 gen_cnt  out  GEN_BITS  generations completed in the current or last run.
REQ-020 cmd  out  PE_CMD_BITS  command to the array.
REQ-021 state_out  out  PE_STATE_BITS  write data to the array state_in.
REQ-022 adr_x_i / adr_y_i  out  XB / YB  array write address.
REQ-023 adr_x_o / adr_y_o  out  XB / YB  array read address.
REQ-024 state_in / active  in  PE_STATE_BITS / 1  array read data (combinational from adr_*_o) and array activity flag.

Function
REQ-025 The FSM SHALL have the states IDLE, LOAD, RUN, DUMP_ADDR and DUMP_HOLD.
REQ-026 In IDLE, start_* SHALL be accepted with priority load > run > dump; start_* outside IDLE SHALL be ignored.
REQ-027 Acceptance SHALL clear the x/y counters to 0; state SHALL change on the next edge.
REQ-028 Raster order SHALL be x fastest: x wraps from N_PX-1 to 0 and increments y; the last cell is (N_PX-1, N_PY-1).
REQ-029 LOAD: in_ready SHALL be high; each in_valid&in_ready beat SHALL drive, combinationally in the same cycle, cmd=CMD_LOAD, state_out=in_data and adr_*_i equal to the counters.
REQ-030 LOAD: the counters SHALL advance at the edge that ends a beat.
REQ-031 LOAD: with no beat in a cycle, cmd SHALL be CMD_NOP.
REQ-032 LOAD: after the beat on the last cell, the FSM SHALL go to IDLE and pulse done.
REQ-033 RUN: cmd SHALL be CMD_STEP for exactly run_gens consecutive cycles, and gen_cnt SHALL increment each STEP cycle.
REQ-034 RUN: at gen_cnt==run_gens, the FSM SHALL go to IDLE, pulse done and drive CMD_NOP.
REQ-035 RUN: run_gens=0 SHALL issue no STEP; done SHALL pulse the cycle after acceptance.
REQ-036 RUN: the active input SHALL be ignored.
REQ-037 gen_cnt SHALL clear on start_run acceptance and hold its value after completion.
REQ-038 DUMP_ADDR: adr_*_o SHALL equal the counters; the next edge SHALL register state_in into out_data, set out_valid and enter DUMP_HOLD.
REQ-039 DUMP_HOLD: out_data/out_last SHALL be stable while out_valid&!out_ready.
REQ-040 DUMP_HOLD: on accept, the FSM SHALL clear out_valid and advance the counters to DUMP_ADDR, or go to IDLE with a done pulse after the last cell.
REQ-041 DUMP: throughput SHALL be one cell per 2 cycles at best, and cmd SHALL be CMD_NOP throughout.
REQ-042 in_ready SHALL be 0 outside LOAD.
REQ-043 out_valid SHALL be 0 outside DUMP_HOLD.
REQ-044 adr_*_i SHALL be 0 outside LOAD.
REQ-045 adr_*_o SHALL hold the counters in DUMP states and 0 otherwise.

Reset
REQ-046 While reset is high, asynchronously: FSM=IDLE; counters, gen_cnt, out_data=0; out_valid, out_last, done, busy=0; cmd=CMD_NOP.
REQ-047 Reset mid-operation SHALL abort it with no done pulse; the first cycle after release SHALL be IDLE.

Verification
REQ-048 4x4 array; start_load plus 16 beats with data=x^y and in_valid gaps -> 16 CMD_LOAD cycles at raster addresses; done pulses once after beat 16.
REQ-049 start_run with run_gens=5 -> exactly 5 consecutive CMD_STEP cycles; gen_cnt=5; done pulse; then CMD_NOP.
REQ-050 run_gens=0 -> no CMD_STEP; done pulses 1 cycle after start.
REQ-051 Dump of a 4x4 array with an array model, out_ready stalled 3 cycles on cell 7 -> 16 beats in raster order; out_data held during the stall; out_last only on beat 16.
REQ-052 start_load, start_run and start_dump together in IDLE -> LOAD only; start_run during LOAD ignored.
REQ-053 Reset asserted mid-DUMP on cell 5 -> outputs are reset values immediately; no done; IDLE after release.
